silly_function: RTL and testbench
=================================

// Module: silly_function
// PURPOSE
//  Three-input Boolean function y = (~a & ~b & ~c) | (a & ~b) for glue logic.
//  The combinational output y is the primary result and has zero latency.
//  A clocked shadow path gives a registered copy, a valid flag and optional statistics.
// PARAMETERS
//  CNT_W   16   width of the statistics counters (>=2)
// PORTS
//  clk       in   1      single clock, rising edge
//  rst_n     in   1      asynchronous active-low reset
//  a         in   1      function input (MSB of truth-table index)
//  b         in   1      function input
//  c         in   1      function input (LSB of truth-table index)
//  en        in   1      sample enable for the registered path
//  y         out  1      combinational result
//  y_q       out  1      registered result
//  y_valid   out  1      y_q holds a sampled result
//  eval_cnt  out  CNT_W  count of sampled evaluations (STATS only)
//  ones_cnt  out  CNT_W  count of sampled evaluations with result 1 (STATS only)
// BEHAVIOUR
//  - Clock and reset: one clock; reset is asynchronous and active-low.
//  - Truth table, abc->y: 000->1, 001->0, 010->0, 011->0, 100->1, 101->1, 110->0, 111->0.
//  - y is purely combinational from a, b and c.
//  - y does not depend on clk, rst_n or en; it is valid while rst_n is low or floating.
//  - y must settle within the same time step as an input change (no clock needed).
//  - If any input is X or Z, y may be X. No X-masking is required.
//  - Reset (rst_n=0, asynchronous): y_q=0, y_valid=0, eval_cnt=0, ones_cnt=0.
//  - Registered path: on a rising clk edge with rst_n=1 and en=1, y_q <= f(a,b,c) and y_valid <= 1.
//  - Latency of the registered path is 1 cycle.
//  - With en=0, y_q and y_valid hold their values.
//  - y_valid stays 1 until the next reset.
//  - Reset asserted mid-operation clears all registers immediately, without waiting for a clock edge.
//  - Reset deassertion is synchronised by the system. The first capture is on the first edge where rst_n=1 and en=1.
// CONFIGURATION
//  Macro SILLY_FUNCTION_STATS_EN.
//  - Defined: on each enabled edge, eval_cnt increments by 1.
//  - Defined: on each enabled edge where f(a,b,c)=1, ones_cnt also increments by 1.
//  - Both counters saturate at 2^CNT_W-1 and never wrap.
//  - Both counters hold when en=0.
//  - Undefined: eval_cnt and ones_cnt are tied to 0 and no counter flops are built.
//  - y, y_q and y_valid behave identically with or without the macro.
// TESTING
//  1 Exhaustive combinational check: apply all 8 abc values with 1 time unit of settle each, no clock.
//    Required y sequence for abc=000..111: 1,0,0,0,1,1,0,0. Expect 0 errors.
//  2 Reset: rst_n=0 mid-run with y_q=1 and counters non-zero.
//    Required: y_q=0, y_valid=0 and counters=0 before the next edge; y still follows abc.
//  3 Registered path: en=1, abc=100, one edge -> y_q=1, y_valid=1.
//    Then en=0, abc=010, edge -> y_q stays 1.
//  4 Stats (macro defined): 8 enabled edges over abc=000..111 -> eval_cnt=8, ones_cnt=3.
//  5 Saturation (macro defined, CNT_W=2): 5 enabled edges with abc=000 -> eval_cnt=3, ones_cnt=3.
//  6 Macro undefined: repeat scenario 4 -> eval_cnt=0, ones_cnt=0; y and y_q match scenario 4.

Source files
------------

// File: rtl/silly_function.sv
`default_nettype none
// ============================================================================
//  Module      : silly_function
//  Description : Three-input Boolean glue function
//                   y = (~a & ~b & ~c) | (a & ~b)
//                with a zero-latency combinational result and a clocked
//                shadow path. The shadow path provides a registered copy of
//                the result, a sticky valid flag and optional saturating
//                statistics counters.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Configuration macro:
//     SILLY_FUNCTION_STATS_EN
//        defined   : eval_cnt / ones_cnt count sampled evaluations
//        undefined : eval_cnt / ones_cnt tied to 0, no counter flops
// ----------------------------------------------------------------------------
//  Parameters:
//     CNT_W     width of the statistics counters (>= 2)
//  Ports:
//     clk       in   1      clock, rising edge active
//     rst_n     in   1      asynchronous active-low reset
//     a         in   1      function input, MSB of truth-table index
//     b         in   1      function input
//     c         in   1      function input, LSB of truth-table index
//     en        in   1      sample enable for the registered path
//     y         out  1      combinational result
//     y_q       out  1      registered result
//     y_valid   out  1      y_q holds a sampled result
//     eval_cnt  out  CNT_W  sampled evaluations (stats build only)
//     ones_cnt  out  CNT_W  sampled evaluations with result 1 (stats only)
// ============================================================================
module silly_function #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   input  logic             en,
   output logic             y,
   output logic             y_q,
   output logic             y_valid,
   output logic [CNT_W-1:0] eval_cnt,
   output logic [CNT_W-1:0] ones_cnt
);

   // ------------------------------------------------------------------------
   // Combinational function. Deliberately independent of clk, rst_n and en
   // so it stays usable as plain glue logic while the block is in reset.
   // ------------------------------------------------------------------------
   logic w_f;

   assign w_f = (~a & ~b & ~c) | (a & ~b);
   assign y   = w_f;

   // ------------------------------------------------------------------------
   // Registered shadow path. y_valid is sticky: once any enabled sample has
   // been taken it only returns to 0 through reset.
   // ------------------------------------------------------------------------
   logic r_y_q;
   logic r_y_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y_q     <= 1'b0;
         r_y_valid <= 1'b0;
      end else if (en) begin
         r_y_q     <= w_f;
         r_y_valid <= 1'b1;
      end
   end

   assign y_q     = r_y_q;
   assign y_valid = r_y_valid;

   // ------------------------------------------------------------------------
   // Optional statistics. Counters saturate at all-ones rather than wrapping
   // so a long-running count never appears to restart from a small value.
   // ------------------------------------------------------------------------
`ifdef SILLY_FUNCTION_STATS_EN
   localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] r_eval_cnt;
   logic [CNT_W-1:0] r_ones_cnt;
   logic             w_eval_sat;
   logic             w_ones_sat;

   assign w_eval_sat = (r_eval_cnt == C_CNT_MAX);
   assign w_ones_sat = (r_ones_cnt == C_CNT_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_eval_cnt <= '0;
         r_ones_cnt <= '0;
      end else if (en) begin
         if (!w_eval_sat) begin
            r_eval_cnt <= r_eval_cnt + C_CNT_ONE;
         end
         if (w_f && !w_ones_sat) begin
            r_ones_cnt <= r_ones_cnt + C_CNT_ONE;
         end
      end
   end

   assign eval_cnt = r_eval_cnt;
   assign ones_cnt = r_ones_cnt;
`else
   assign eval_cnt = '0;
   assign ones_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_silly_function.sv
`default_nettype none
// ============================================================================
//  Module      : tb_silly_function
//  Description : Self-checking bench for silly_function. Two instances are
//                driven with identical stimulus: one with CNT_W=16 and one
//                with CNT_W=2 to exercise counter saturation. Registered
//                results are predicted into a queue when an enabled edge is
//                driven and popped after that edge.
//                Stats expectations follow SILLY_FUNCTION_STATS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_silly_function;

   logic        clk;
   logic        rst_n;
   logic        a, b, c;
   logic        en;

   logic        y_w,  y_q_w,  y_valid_w;
   logic [15:0] eval_w, ones_w;
   logic        y_n,  y_q_n,  y_valid_n;
   logic [1:0]  eval_n, ones_n;

   int          n_tot = 0;
   int          n_bad = 0;

   // Expected result per abc index, bit i = f(abc == i): 000,100,101 -> 1
   logic [7:0]  c_tt = 8'b0011_0001;
   logic        q_exp[$];
   logic        r_yq_exp;

`ifdef SILLY_FUNCTION_STATS_EN
   localparam bit c_stats = 1'b1;
`else
   localparam bit c_stats = 1'b0;
`endif

   silly_function #(.CNT_W(16)) u_dut_w (
      .clk      (clk),
      .rst_n    (rst_n),
      .a        (a),
      .b        (b),
      .c        (c),
      .en       (en),
      .y        (y_w),
      .y_q      (y_q_w),
      .y_valid  (y_valid_w),
      .eval_cnt (eval_w),
      .ones_cnt (ones_w)
   );

   silly_function #(.CNT_W(2)) u_dut_n (
      .clk      (clk),
      .rst_n    (rst_n),
      .a        (a),
      .b        (b),
      .c        (c),
      .en       (en),
      .y        (y_n),
      .y_q      (y_q_n),
      .y_valid  (y_valid_n),
      .eval_cnt (eval_n),
      .ones_cnt (ones_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive on the falling edge, check just after the rise.
   task automatic cyc(input logic [2:0] v, input logic e);
      @(negedge clk);
      {a, b, c} = v;
      en        = e;
      if (e) q_exp.push_back(c_tt[v]);
      @(posedge clk);
      #1;
      if (e) begin
         if (q_exp.size() == 0) begin
            chk("queue_underflow", 32'd1, 32'd0);
         end else begin
            r_yq_exp = q_exp.pop_front();
         end
         chk("y_valid", {31'd0, y_valid_w}, 32'd1);
      end
      chk("y_q_w", {31'd0, y_q_w}, {31'd0, r_yq_exp});
      chk("y_q_n", {31'd0, y_q_n}, {31'd0, r_yq_exp});
   endtask

   task automatic chk_cnt(input string tag, input int ew, input int ow, input int en_, input int on_);
      chk({tag, "_eval_w"}, {16'd0, eval_w}, c_stats ? ew  : 0);
      chk({tag, "_ones_w"}, {16'd0, ones_w}, c_stats ? ow  : 0);
      chk({tag, "_eval_n"}, {30'd0, eval_n}, c_stats ? en_ : 0);
      chk({tag, "_ones_n"}, {30'd0, ones_n}, c_stats ? on_ : 0);
   endtask

   initial begin
      logic [2:0] v;
      rst_n    = 1'b0;
      en       = 1'b0;
      {a, b, c} = 3'b000;
      r_yq_exp = 1'b0;
      #2;

      // Exhaustive combinational check while held in reset.
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         {a, b, c} = v;
         #1;
         chk("comb_y_w", {31'd0, y_w}, {31'd0, c_tt[v]});
         chk("comb_y_n", {31'd0, y_n}, {31'd0, c_tt[v]});
      end

      // Reset state.
      chk("rst_y_q",     {31'd0, y_q_w},     32'd0);
      chk("rst_y_valid", {31'd0, y_valid_w}, 32'd0);
      chk_cnt("rst", 0, 0, 0, 0);

      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_y_valid", {31'd0, y_valid_w}, 32'd0);

      // Registered path: capture with abc=100, then hold with en=0.
      cyc(3'b100, 1'b1);
      chk("cap_y_valid_n", {31'd0, y_valid_n}, 32'd1);
      cyc(3'b010, 1'b0);
      chk("hold_y_valid", {31'd0, y_valid_w}, 32'd1);
      chk_cnt("hold", 1, 1, 1, 1);

      // Asynchronous reset mid-cycle with y_q=1 and counters non-zero.
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_y_q",     {31'd0, y_q_w},     32'd0);
      chk("arst_y_valid", {31'd0, y_valid_w}, 32'd0);
      chk_cnt("arst", 0, 0, 0, 0);
      r_yq_exp = 1'b0;
      {a, b, c} = 3'b101;
      #1;
      chk("arst_comb_y", {31'd0, y_w}, 32'd1);
      {a, b, c} = 3'b001;
      #1;
      chk("arst_comb_y2", {31'd0, y_w}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Stats: 8 enabled edges over abc=000..111.
      for (int i = 0; i < 8; i++) cyc(3'(i), 1'b1);
      chk_cnt("sweep", 8, 3, 3, 3);
      cyc(3'b000, 1'b0);
      chk_cnt("sweep_hold", 8, 3, 3, 3);

      // Saturation: reset, then 5 enabled edges with abc=000.
      @(negedge clk);
      rst_n = 1'b0;
      r_yq_exp = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) cyc(3'b000, 1'b1);
      chk_cnt("sat", 5, 5, 3, 3);
      cyc(3'b110, 1'b1);
      chk_cnt("sat_zero", 6, 5, 3, 3);

      chk("queue_empty", q_exp.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
